// File: rtl/gmii_rx_fifo9_pkg.sv
// Shared constants and types for the GMII receive-to-FIFO path.
// Holds FSM states, framing bytes, CRC constants and status-bit layout.
`timescale 1ns/1ps
package gmii_rx_fifo9_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_DATA,
    S_TERM,
    S_DROP
  } state_e;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

  localparam int ST_CRC_OK = 0;
  localparam int ST_OVF    = 1;
  localparam int ST_RX_ER  = 2;
  localparam int ST_RUNT   = 3;

  // Octet data enters LSB first, as it arrives on the wire.
  function automatic logic [31:0] crc32_byte(
    input logic [31:0] crc,
    input logic [7:0]  data
  );
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/gmii_rx_fifo9_crc32_d8.sv
// Byte-wide Ethernet CRC-32 accumulator.
// init loads all-ones; data_en folds one octet into the register.
`timescale 1ns/1ps
module crc32_d8
  import gmii_rx_fifo9_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        data_en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_q;
  logic [31:0] crc_d;

  always_comb begin
    crc_d = crc_q;
    if (init)         crc_d = '1;
    else if (data_en) crc_d = crc32_byte(crc_q, data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= '0;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/gmii_rx_fifo9.sv
// GMII receiver: strips preamble/SFD and writes 9-bit words to a FIFO.
// Each frame that reaches DATA is followed by one status word.
`timescale 1ns/1ps
module gmii_rx_fifo9
  import gmii_rx_fifo9_pkg::*;
#(
  parameter int unsigned MIN_LEN = 64
) (
  input  logic       gmii_rx_clk,
  input  logic       sys_rst,
  input  logic       gmii_rx_dv,
  input  logic [7:0] gmii_rxd,
  input  logic       gmii_rx_er,
  output logic [8:0] din,
  input  logic       full,
  output logic       wr_en,
  output logic       wr_clk
);

  logic        dv_q, dv_d;
  logic [7:0]  rxd_q, rxd_d;
  logic        er_q, er_d;
  state_e      state_q, state_d;
  logic        ovf_q, ovf_d;
  logic        er_seen_q, er_seen_d;
  logic [15:0] cnt_q, cnt_d;
  logic        wr_en_q, wr_en_d;
  logic [8:0]  din_q, din_d;

  logic        crc_init;
  logic        crc_en;
  logic        start_frame;
  logic [31:0] crc_val;
  logic        crc_ok;
  logic [7:0]  status;

  assign wr_clk = gmii_rx_clk;
  assign din    = din_q;
  assign wr_en  = wr_en_q;

  assign dv_d  = gmii_rx_dv;
  assign rxd_d = gmii_rxd;
  assign er_d  = gmii_rx_er;

  crc32_d8 u_crc (
    .clk     (gmii_rx_clk),
    .rst     (sys_rst),
    .init    (crc_init),
    .data_en (crc_en),
    .data    (rxd_q),
    .crc     (crc_val)
  );

  assign crc_ok = (crc_val == CRC_RESIDUE);

  // A frame that overflowed or flagged rx_er is never reported good.
  always_comb begin
    status            = '0;
    status[ST_CRC_OK] = crc_ok & ~ovf_q & ~er_seen_q;
    status[ST_OVF]    = ovf_q;
    status[ST_RX_ER]  = er_seen_q;
    status[ST_RUNT]   = ({16'd0, cnt_q} < MIN_LEN);
  end

  always_comb begin
    state_d     = state_q;
    ovf_d       = ovf_q;
    er_seen_d   = er_seen_q;
    cnt_d       = cnt_q;
    wr_en_d     = 1'b0;
    din_d       = din_q;
    crc_init    = 1'b0;
    crc_en      = 1'b0;
    start_frame = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dv_q) begin
          if (rxd_q == PREAMBLE_BYTE) state_d = S_PRE;
          else if (rxd_q == SFD_BYTE) start_frame = 1'b1;
          else state_d = S_DROP;
        end
      end
      S_PRE: begin
        if (!dv_q) state_d = S_IDLE;
        else if (rxd_q == SFD_BYTE) start_frame = 1'b1;
        else if (rxd_q != PREAMBLE_BYTE) state_d = S_DROP;
      end
      S_DATA: begin
        if (dv_q) begin
          crc_en = 1'b1;
          if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
          if (er_q) er_seen_d = 1'b1;
          if (ovf_q || full) begin
            ovf_d = 1'b1;
          end else begin
            wr_en_d = 1'b1;
            din_d   = {1'b1, rxd_q};
          end
        end else begin
          state_d = S_TERM;
        end
      end
      S_TERM: begin
        if (!full) begin
          wr_en_d = 1'b1;
          din_d   = {1'b0, status};
          state_d = dv_q ? S_DROP : S_IDLE;
        end
      end
      S_DROP: begin
        if (!dv_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (start_frame) begin
      state_d   = S_DATA;
      ovf_d     = 1'b0;
      er_seen_d = 1'b0;
      cnt_d     = '0;
      crc_init  = 1'b1;
    end
  end

  always_ff @(posedge gmii_rx_clk) begin
    if (sys_rst) begin
      dv_q      <= 1'b0;
      rxd_q     <= '0;
      er_q      <= 1'b0;
      state_q   <= S_IDLE;
      ovf_q     <= 1'b0;
      er_seen_q <= 1'b0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      din_q     <= '0;
    end else begin
      dv_q      <= dv_d;
      rxd_q     <= rxd_d;
      er_q      <= er_d;
      state_q   <= state_d;
      ovf_q     <= ovf_d;
      er_seen_q <= er_seen_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      din_q     <= din_d;
    end
  end

endmodule
